// File: rtl/pipelined_tree_adder.sv
// Pipelined unsigned adder tree: NUM_IN operands reduced pairwise through
// log2(NUM_IN) registered levels, with a valid/ready handshake and global stall.

module tree_node #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-2:0] a,
    input  logic [W-2:0] b,
    output logic [W-1:0] sum
);
    always_ff @(posedge clk) begin
        if (!reset_n)
            sum <= '0;
        else if (en)
            sum <= {1'b0, a} + {1'b0, b};
    end
endmodule

module pipelined_tree_adder #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_IN*WIDTH-1:0]           in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH+$clog2(NUM_IN)-1:0]   out_sum
);
    localparam int LEVELS = $clog2(NUM_IN);

    logic              advance;
    logic [LEVELS:1]   vld_q;
    logic [LEVELS:0]   vld_pipe;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign vld_pipe  = {vld_q, in_valid};
    assign out_valid = vld_pipe[LEVELS];

    always_ff @(posedge clk) begin
        if (!reset_n)
            vld_q <= '0;
        else if (advance)
            vld_q <= vld_pipe[LEVELS-1:0];
    end

    // Data registers only load behind a valid stage, so out_sum stays 0 after
    // reset until the first real result arrives.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int N = NUM_IN >> k;
        localparam int W = WIDTH + k;
        logic [N-1:0][W-1:0] node;
        if (k == 0) begin : g_src
            assign node = in_data;
        end else begin : g_add
            for (genvar j = 0; j < N; j++) begin : g_node
                tree_node #(.W(W)) u_node (
                    .clk     (clk),
                    .reset_n (reset_n),
                    .en      (advance && vld_pipe[k-1]),
                    .a       (g_lvl[k-1].node[2*j]),
                    .b       (g_lvl[k-1].node[2*j+1]),
                    .sum     (node[j])
                );
            end
        end
    end

    assign out_sum = g_lvl[LEVELS].node;
endmodule

// File: tb/tb_pipelined_tree_adder.sv
// Directed bench for pipelined_tree_adder: default 4x8 instance plus an 8x4 instance.

module tb_pipelined_tree_adder;
    logic        clk = 1'b0;
    logic        reset_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data;
    logic [9:0]  out_sum;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data;
    logic [6:0]  b_out_sum;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_tree_adder #(.WIDTH(8), .NUM_IN(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    pipelined_tree_adder #(.WIDTH(4), .NUM_IN(8)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum)
    );

    function automatic logic [31:0] pack4(input logic [7:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        step(); step();
        reset_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum",   32'(out_sum), 0);
        chk("rst_in_ready",  32'(in_ready), 1);
        chk("rst_b_out_sum", 32'(b_out_sum), 0);

        // Single operand set, latency 2
        in_valid = 1'b1; in_data = pack4(0, 3, 1, 255);
        step();
        in_valid = 1'b0; in_data = '0;
        chk("t1_lat_c1", 32'(out_valid), 0);
        step();
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_sum",   32'(out_sum), 259);
        step();
        chk("t1_pulse_end", 32'(out_valid), 0);

        // Max values
        in_valid = 1'b1; in_data = pack4(255, 255, 255, 255);
        step();
        in_valid = 1'b0;
        step();
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_sum",   32'(out_sum), 1020);
        step();

        // Back-to-back streaming
        in_valid = 1'b1; in_data = pack4(10, 13, 9, 10);
        step();
        in_data = pack4(15, 15, 109, 37);
        chk("t3_empty", 32'(out_valid), 0);
        step();
        chk("t3_v0", 32'(out_valid), 1);
        chk("t3_s0", 32'(out_sum), 42);
        in_data = pack4(0, 9, 45, 45);
        step();
        in_valid = 1'b0;
        chk("t3_v1", 32'(out_valid), 1);
        chk("t3_s1", 32'(out_sum), 176);
        step();
        chk("t3_v2", 32'(out_valid), 1);
        chk("t3_s2", 32'(out_sum), 99);
        step();
        chk("t3_drain", 32'(out_valid), 0);

        // Backpressure
        in_valid = 1'b1; in_data = pack4(0, 3, 1, 255);
        step();
        in_data = pack4(255, 255, 255, 255);
        step();
        chk("t4_sum0", 32'(out_sum), 259);
        out_ready = 1'b0; in_data = pack4(10, 13, 9, 10);
        #1;
        chk("t4_in_ready_low", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_valid", 32'(out_valid), 1);
            chk("t4_hold_sum",   32'(out_sum), 259);
            chk("t4_hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t4_q1_valid", 32'(out_valid), 1);
        chk("t4_q1_sum",   32'(out_sum), 1020);
        step();
        chk("t4_q2_valid", 32'(out_valid), 1);
        chk("t4_q2_sum",   32'(out_sum), 42);
        step();
        chk("t4_drain", 32'(out_valid), 0);

        // Reset with sets in flight
        in_valid = 1'b1; in_data = pack4(10, 13, 9, 10);
        step();
        in_data = pack4(15, 15, 109, 37);
        step();
        chk("t5_pre_valid", 32'(out_valid), 1);
        reset_n = 1'b0; in_data = pack4(0, 9, 45, 45);
        step();
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_sum",   32'(out_sum), 0);
        chk("t5_rst_ready", 32'(in_ready), 1);
        reset_n = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_stale_valid", 32'(out_valid), 0);
            chk("t5_no_stale_sum",   32'(out_sum), 0);
        end

        // 8 operands of 4 bits, latency 3
        b_in_valid = 1'b1; b_in_data = 32'hFFFF_FFFF;
        step();
        b_in_valid = 1'b0; b_in_data = '0;
        chk("t6_lat_c1", 32'(b_out_valid), 0);
        step();
        chk("t6_lat_c2", 32'(b_out_valid), 0);
        step();
        chk("t6_valid", 32'(b_out_valid), 1);
        chk("t6_sum",   32'(b_out_sum), 120);
        step();
        chk("t6_pulse_end", 32'(b_out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_tree_adder.md
Name: pipelined_tree_adder

Overview:
- Parametrised, pipelined unsigned adder tree. Sums NUM_IN operands of WIDTH bits through log2(NUM_IN) registered levels of pairwise adds.
- Carries a valid/ready handshake so it can sit in a streaming datapath between a sample source and a downstream consumer.
- Successor to the fixed-width combinational tree adder: width, fan-in and pipelining are now generalised, and backpressure is new.

Parameters:
- WIDTH, 8, bit width of each unsigned input operand (1..32).
- NUM_IN, 4, number of operands; power of two, 2..16.
- LEVELS (localparam, not overridable), log2(NUM_IN), number of adder levels and register stages.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data holds a valid operand set this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  NUM_IN*WIDTH  packed operands; operand i = in_data[i*WIDTH +: WIDTH].
- out_valid  output  1  out_sum holds a valid result.
- out_ready  input  1  consumer accepts out_sum this cycle.
- out_sum  output  WIDTH+LEVELS  full-precision sum of one operand set.

Behaviour:
- Reset: sampled only at a rising clk edge with reset_n=0.
  - All stage valid bits, all stage data registers, out_valid and out_sum clear to 0.
  - Any in-flight operand sets are discarded.
  - in_ready is combinational and reads 1 once the stage valids are 0.
- Tree structure:
  - Level k (1..LEVELS) holds NUM_IN/2^k registered nodes, each WIDTH+k bits wide.
  - Node j of level k = node 2j + node 2j+1 of level k-1. Level 0 is the raw operands.
  - All adds are unsigned and zero-extended to the node width. No truncation or overflow is possible.
  - out_sum is the single level-LEVELS register.
- Advance signal: advance = !out_valid || out_ready.
  - Global stall: every stage register and stage valid bit loads only when advance=1.
  - When advance=0, all stages hold value and valid, and out_sum stays stable.
- Input handshake:
  - in_ready = advance (combinational).
  - Transfer occurs when in_valid && in_ready.
  - Stage-1 valid loads in_valid && advance. A bubble (in_valid=0) propagates as valid=0.
- Output handshake:
  - Transfer occurs when out_valid && out_ready.
  - out_valid/out_sum must not change while out_valid=1 and out_ready=0.
- Latency and throughput:
  - Latency is exactly LEVELS cycles from the input transfer edge to out_valid=1, with out_ready held high.
  - Throughput is one result per cycle; back-to-back inputs produce back-to-back outputs in order.
- Simultaneous events:
  - out transfer and in transfer in the same cycle are both legal; the pipeline shifts by one.
  - reset_n=0 overrides all handshake activity.
- Data registers of invalid stages may hold stale values, but out_sum must be 0 after reset until the first valid result.

Test Plan:
- Defaults (WIDTH=8, NUM_IN=4), out_ready=1: operands {0,3,1,255} with one in_valid pulse -> out_valid high for exactly 1 cycle, 2 cycles later, out_sum=259.
- Defaults, max-value check: operands {255,255,255,255} -> out_sum=1020 (10 bits, no overflow).
- Defaults, streaming: back-to-back sets {10,13,9,10}, {15,15,109,37}, {0,9,45,45} -> out_sum 42, 176, 99 on consecutive cycles, in order.
- Backpressure: out_ready=0 while the first result is valid -> in_ready=0; out_sum holds 259 for 5 cycles; after out_ready=1 the queued results follow with none lost or duplicated.
- Reset mid-operation: reset_n=0 for one edge with 2 sets in flight -> out_valid=0 and out_sum=0 next cycle; no stale result ever emerges.
- WIDTH=4, NUM_IN=8: all operands 15 -> out_sum=120 (7 bits), latency 3 cycles.
